// File: rtl/sprite_frame_scheduler.sv
// Per-frame sprite sequencer: on each frame tick, erases every live channel's sprite at its
// last drawn position and redraws it at the new one, one clipped pixel per cycle.
module sprite_frame_scheduler #(
    parameter int unsigned         NUM_CH       = 7,
    parameter int unsigned         X_W          = 8,
    parameter int unsigned         Y_W          = 7,
    parameter int unsigned         COLOUR_W     = 3,
    parameter int unsigned         X_MAX        = 159,
    parameter int unsigned         Y_MAX        = 119,
    parameter logic [COLOUR_W-1:0] DRAW_COLOUR  = 3'b111,
    parameter logic [COLOUR_W-1:0] ERASE_COLOUR = 3'b000
) (
    input  logic                                      clock,
    input  logic                                      resetn,
    input  logic                                      frame_tick,
    input  logic [NUM_CH-1:0]                         ch_enable,
    input  logic [NUM_CH*X_W-1:0]                     ch_x,
    input  logic [NUM_CH*Y_W-1:0]                     ch_y,
    input  logic                                      stall,
    output logic                                      plot,
    output logic [X_W-1:0]                            plot_x,
    output logic [Y_W-1:0]                            plot_y,
    output logic [COLOUR_W-1:0]                       colour,
    output logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] cur_ch,
    output logic                                      busy,
    output logic                                      frame_done,
    output logic                                      overrun
);

    localparam int unsigned     CH_W    = $clog2(NUM_CH > 1 ? NUM_CH : 2);
    localparam logic [3:0]      LastPix = 4'd12;
    localparam logic [CH_W-1:0] LastCh  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {StIdle, StScan, StErase, StDraw, StDone} state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [3:0]          pix_idx_q, pix_idx_d;
    logic                overrun_q;
    logic [NUM_CH-1:0]   shadow_en_q;
    logic [NUM_CH*X_W-1:0] shadow_x_q, saved_x_q;
    logic [NUM_CH*Y_W-1:0] shadow_y_q, saved_y_q;
    logic [NUM_CH-1:0]   was_drawn_q;

    logic                capture, commit, clr_drawn;
    logic [X_W-1:0]      anchor_x;
    logic [Y_W-1:0]      anchor_y;
    logic signed [3:0]   off_dx, off_dy;
    logic [X_W:0]        pix_x_s;
    logic [Y_W:0]        pix_y_s;
    logic                walking, on_screen, pix_done, last_ch;

    // Bird sprite: beak/head column at the anchor, body and wings trailing to the left.
    function automatic logic signed [3:0] sprite_dx(input logic [3:0] idx);
        case (idx)
            4'd2:                sprite_dx = -4'sd1;
            4'd3:                sprite_dx = -4'sd2;
            4'd4, 4'd7, 4'd8:    sprite_dx = -4'sd3;
            4'd5, 4'd9, 4'd10:   sprite_dx = -4'sd4;
            4'd6, 4'd11, 4'd12:  sprite_dx = -4'sd5;
            default:             sprite_dx = 4'sd0;
        endcase
    endfunction

    function automatic logic signed [3:0] sprite_dy(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd7: sprite_dy = 4'sd1;
            4'd8:       sprite_dy = -4'sd1;
            4'd9:       sprite_dy = 4'sd2;
            4'd10:      sprite_dy = -4'sd2;
            4'd11:      sprite_dy = 4'sd3;
            4'd12:      sprite_dy = -4'sd3;
            default:    sprite_dy = 4'sd0;
        endcase
    endfunction

    // Current pixel: anchor + offset, one bit wider so negative results are caught by the MSB.
    always_comb begin
        walking = (state_q == StErase) || (state_q == StDraw);
        if (state_q == StErase) begin
            anchor_x = saved_x_q[cur_ch_q*X_W +: X_W];
            anchor_y = saved_y_q[cur_ch_q*Y_W +: Y_W];
        end else begin
            anchor_x = shadow_x_q[cur_ch_q*X_W +: X_W];
            anchor_y = shadow_y_q[cur_ch_q*Y_W +: Y_W];
        end
        off_dx    = sprite_dx(pix_idx_q);
        off_dy    = sprite_dy(pix_idx_q);
        pix_x_s   = {1'b0, anchor_x} + {{(X_W-3){off_dx[3]}}, off_dx};
        pix_y_s   = {1'b0, anchor_y} + {{(Y_W-3){off_dy[3]}}, off_dy};
        on_screen = !pix_x_s[X_W] && !pix_y_s[Y_W] &&
                    (pix_x_s[X_W-1:0] <= X_W'(X_MAX)) && (pix_y_s[Y_W-1:0] <= Y_W'(Y_MAX));
        // Clipped pixels never wait on the plotter.
        pix_done  = walking && (!on_screen || !stall);
        last_ch   = (cur_ch_q == LastCh);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cur_ch_q  <= '0;
            pix_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            pix_idx_q <= pix_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        pix_idx_d = pix_idx_q;
        capture   = 1'b0;
        commit    = 1'b0;
        clr_drawn = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    capture  = 1'b1;
                    cur_ch_d = '0;
                    state_d  = StScan;
                end
            end
            StScan: begin
                pix_idx_d = '0;
                if (was_drawn_q[cur_ch_q]) begin
                    state_d = StErase;
                end else if (shadow_en_q[cur_ch_q]) begin
                    state_d = StDraw;
                end else if (last_ch) begin
                    state_d = StDone;
                end else begin
                    cur_ch_d = cur_ch_q + CH_W'(1);
                end
            end
            StErase: begin
                if (pix_done) begin
                    if (pix_idx_q == LastPix) begin
                        pix_idx_d = '0;
                        if (shadow_en_q[cur_ch_q]) begin
                            state_d = StDraw;
                        end else begin
                            clr_drawn = 1'b1;
                            if (last_ch) begin
                                state_d = StDone;
                            end else begin
                                cur_ch_d = cur_ch_q + CH_W'(1);
                                state_d  = StScan;
                            end
                        end
                    end else begin
                        pix_idx_d = pix_idx_q + 4'd1;
                    end
                end
            end
            StDraw: begin
                if (pix_done) begin
                    if (pix_idx_q == LastPix) begin
                        pix_idx_d = '0;
                        commit    = 1'b1;
                        if (last_ch) begin
                            state_d = StDone;
                        end else begin
                            cur_ch_d = cur_ch_q + CH_W'(1);
                            state_d  = StScan;
                        end
                    end else begin
                        pix_idx_d = pix_idx_q + 4'd1;
                    end
                end
            end
            StDone: begin
                cur_ch_d = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        plot       = walking && on_screen;
        plot_x     = plot ? pix_x_s[X_W-1:0] : '0;
        plot_y     = plot ? pix_y_s[Y_W-1:0] : '0;
        colour     = '0;
        if (plot) begin
            colour = (state_q == StErase) ? ERASE_COLOUR : DRAW_COLOUR;
        end
        cur_ch     = cur_ch_q;
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
        overrun    = overrun_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overrun_q   <= 1'b0;
            shadow_en_q <= '0;
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            saved_x_q   <= '0;
            saved_y_q   <= '0;
            was_drawn_q <= '0;
        end else begin
            if (frame_tick && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            if (capture) begin
                shadow_en_q <= ch_enable;
                shadow_x_q  <= ch_x;
                shadow_y_q  <= ch_y;
            end
            if (commit) begin
                saved_x_q[cur_ch_q*X_W +: X_W] <= shadow_x_q[cur_ch_q*X_W +: X_W];
                saved_y_q[cur_ch_q*Y_W +: Y_W] <= shadow_y_q[cur_ch_q*Y_W +: Y_W];
                was_drawn_q[cur_ch_q]          <= 1'b1;
            end
            if (clr_drawn) begin
                was_drawn_q[cur_ch_q] <= 1'b0;
            end
        end
    end

endmodule
